// File: rtl/alu_cmd_parser_if.sv
// rtl/alu_cmd_parser_if.sv - byte-in / response-out signal bundle for alu_cmd_parser
interface alu_cmd_parser_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       frame_err;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output tx_data, tx_start, busy, frame_err
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  tx_data, tx_start, busy, frame_err
  );
endinterface

// File: rtl/alu_cmd_parser.sv
// rtl/alu_cmd_parser.sv - assembles {opcode,A,B} frames, runs one 8-bit ALU op, sends {result,status}
module alu_cmd_parser #(
  parameter int CLK_FREQ       = 125000000,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input logic              clk,
  input logic              rst,
  alu_cmd_parser_if.master bus
);
  typedef enum logic [2:0] {
    WAIT_OP, WAIT_A, WAIT_B, EXEC, SEND_RES, HOLD_RES, SEND_STAT, HOLD_STAT
  } state_t;

  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  opcode, a, b, result, status, tx_hold;
  logic [23:0] tmo_cnt;
  logic        hold_armed, frame_err_q;
  logic        tmo_hit, overrun, send_now;
  logic [7:0]  tx_byte, alu_res, alu_stat;
  logic [8:0]  add9, sub9;
  logic [15:0] prod;
  logic        alu_c, alu_v, alu_inv;

  always_comb begin
    state_next = state;
    tmo_hit    = 1'b0;
    send_now   = 1'b0;
    case (state)
      WAIT_OP: if (bus.rx_valid) state_next = WAIT_A;
      WAIT_A, WAIT_B: begin
        if (bus.rx_valid) begin
          state_next = (state == WAIT_A) ? WAIT_B : EXEC;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit    = 1'b1;
          state_next = WAIT_OP;
        end
      end
      EXEC: state_next = SEND_RES;
      SEND_RES, SEND_STAT: begin
        if (!bus.tx_busy) begin
          send_now   = 1'b1;
          state_next = (state == SEND_RES) ? HOLD_RES : HOLD_STAT;
        end
      end
      // The transmitter may take one cycle to raise busy, so the first HOLD cycle is ignored.
      HOLD_RES:  if (hold_armed && !bus.tx_busy) state_next = SEND_STAT;
      HOLD_STAT: if (hold_armed && !bus.tx_busy) state_next = WAIT_OP;
      default:   state_next = WAIT_OP;
    endcase
  end

  assign overrun = bus.rx_valid &&
                   (state inside {EXEC, SEND_RES, HOLD_RES, SEND_STAT, HOLD_STAT});

  assign add9 = {1'b0, a} + {1'b0, b};
  assign sub9 = {1'b0, a} - {1'b0, b};
  assign prod = 16'(a) * 16'(b);

  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_inv = 1'b0;
    case (opcode)
      8'h00: begin
        alu_res = add9[7:0];
        alu_c   = add9[8];
        alu_v   = (a[7] == b[7]) && (add9[7] != a[7]);
      end
      8'h01: begin
        alu_res = sub9[7:0];
        alu_c   = sub9[8];
        alu_v   = (a[7] != b[7]) && (sub9[7] != a[7]);
      end
      8'h02: alu_res = a & b;
      8'h03: alu_res = a | b;
      8'h04: alu_res = a ^ b;
      8'h05: alu_res = a << b[2:0];
      8'h06: alu_res = a >> b[2:0];
      8'h07: begin
        alu_res = prod[7:0];
        alu_c   = |prod[15:8];
      end
      default: alu_inv = 1'b1;
    endcase
    alu_stat = alu_inv ? 8'h80 : {4'b0000, (alu_res == 8'h00), alu_res[7], alu_c, alu_v};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_OP;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode      <= 8'h00;
      a           <= 8'h00;
      b           <= 8'h00;
      result      <= 8'h00;
      status      <= 8'h00;
      tx_hold     <= 8'h00;
      tmo_cnt     <= 24'd0;
      hold_armed  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= tmo_hit || overrun;
      hold_armed  <= (state == HOLD_RES) || (state == HOLD_STAT);
      if ((state == WAIT_A || state == WAIT_B) && !bus.rx_valid) tmo_cnt <= tmo_cnt + 24'd1;
      else tmo_cnt <= 24'd0;
      if (bus.rx_valid) begin
        case (state)
          WAIT_OP: opcode <= bus.rx_data;
          WAIT_A:  a      <= bus.rx_data;
          WAIT_B:  b      <= bus.rx_data;
          default: ;
        endcase
      end
      if (state == EXEC) begin
        result <= alu_res;
        status <= alu_stat;
      end
      if (send_now) tx_hold <= tx_byte;
    end
  end

  // tx_data shows the new byte in the tx_start cycle itself, then holds it until the next start.
  assign tx_byte       = (state == SEND_RES) ? result : status;
  assign bus.tx_data   = send_now ? tx_byte : tx_hold;
  assign bus.tx_start  = send_now;
  assign bus.busy      = (state != WAIT_OP);
  assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_alu_cmd_parser.sv
// tb/tb_alu_cmd_parser.sv - self-checking bench for alu_cmd_parser with a behavioural ALU model
module tb_alu_cmd_parser;
  logic clk, rst;
  alu_cmd_parser_if bus();

  alu_cmd_parser #(.CLK_FREQ(5000), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int busy_len = 0;
  int starts   = 0;
  int errs     = 0;
  int viol     = 0;
  logic [7:0] tx_q[$];

  // Transmitter: raises busy the cycle after tx_start and holds it busy_len cycles.
  initial begin
    int  busy_cnt;
    logic pend;
    busy_cnt    = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      pend = bus.tx_start && !rst;
      @(posedge clk);
      #1;
      if (rst) begin
        bus.tx_busy = 1'b0;
        busy_cnt    = 0;
      end else if (pend && busy_len > 0) begin
        bus.tx_busy = 1'b1;
        busy_cnt    = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) bus.tx_busy = 1'b0;
      end
    end
  end

  initial begin
    logic [7:0] last;
    logic       prev_start;
    last       = 8'h00;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = 8'h00;
      end else begin
        if (bus.frame_err) errs++;
        if (bus.tx_start) begin
          starts++;
          tx_q.push_back(bus.tx_data);
          if (bus.tx_busy || prev_start) viol++;
          last = bus.tx_data;
        end else if (bus.tx_data !== last) begin
          viol++;
        end
      end
      prev_start = bus.tx_start && !rst;
    end
  end

  function automatic logic [15:0] ref_resp(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [7:0] res;
    ua = a;
    ub = b;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    if (op > 8'd7) return 16'h0080;
    case (op)
      8'd0: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      8'd1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
      8'd2: r = ua & ub;
      8'd3: r = ua | ub;
      8'd4: r = ua ^ ub;
      8'd5: r = ua * (2 ** (ub % 8));
      8'd6: r = ua / (2 ** (ub % 8));
      default: begin r = ua * ub; c = (r > 255); end
    endcase
    res = 8'(r & 255);
    return {res, 4'b0000, (res == 8'h00), res[7], c, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (bus.busy && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    check({tag, "_idle"}, bus.busy, 1'b0);
  endtask

  task automatic wait_tx(input int n);
    int cyc;
    cyc = 0;
    while (tx_q.size() < n && cyc < 3000) begin
      tick(1);
      cyc++;
    end
    check("tx_wait", tx_q.size() >= n, 1'b1);
  endtask

  task automatic check_resp(input string tag, input logic [15:0] exp);
    check({tag, "_count"}, tx_q.size(), 2);
    if (tx_q.size() == 2) begin
      check({tag, "_res"}, tx_q[0], exp[15:8]);
      check({tag, "_stat"}, tx_q[1], exp[7:0]);
    end
  endtask

  task automatic do_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int gap, input string tag);
    int e0;
    tx_q.delete();
    e0 = errs;
    send_byte(op);
    tick(gap);
    send_byte(a);
    tick(gap);
    send_byte(b);
    wait_idle(tag);
    check_resp(tag, ref_resp(op, a, b));
    check({tag, "_noerr"}, errs - e0, 0);
  endtask

  initial begin
    int e0, s0;
    logic [7:0] op, a, b;
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    tick(3);
    check("rst_tx_start", bus.tx_start, 1'b0);
    rst = 1'b0;
    tick(1);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);

    // ADD with carry: minimum latency and busy timing with an always-ready transmitter
    busy_len = 0;
    tx_q.delete();
    send_byte(8'h00);
    check("busy_after_op", bus.busy, 1'b1);
    send_byte(8'hFF);
    send_byte(8'h01);
    check("exec_no_start", bus.tx_start, 1'b0);
    tick(1);
    check("lat_tx_start", bus.tx_start, 1'b1);
    check("lat_tx_data", bus.tx_data, 8'h00);
    wait_idle("add_carry");
    check_resp("add_carry", 16'h000A);
    check("add_carry_noerr", errs, 0);

    // Same frame against a slow transmitter
    busy_len = 100;
    s0 = starts;
    do_frame(8'h00, 8'hFF, 8'h01, 0, "hs_add");
    check("hs_starts", starts - s0, 2);
    check("hs_violations", viol, 0);

    busy_len = 3;
    do_frame(8'h01, 8'h10, 8'h20, 0, "sub_borrow");
    check("sub_borrow_exp", ref_resp(8'h01, 8'h10, 8'h20), 16'hF006);
    do_frame(8'h00, 8'h7F, 8'h01, 1, "add_ovf");
    do_frame(8'h07, 8'h10, 8'h10, 0, "mul");
    do_frame(8'h05, 8'h81, 8'h01, 2, "shl");
    do_frame(8'h09, 8'h12, 8'h34, 0, "invalid");
    do_frame(8'h06, 8'h81, 8'h0F, 0, "shr");

    // Timeout in WAIT_B, then resync
    tx_q.delete();
    e0 = errs;
    send_byte(8'h00);
    send_byte(8'h11);
    tick(49);
    check("tmo_not_yet", bus.frame_err, 1'b0);
    tick(1);
    check("tmo_pulse", bus.frame_err, 1'b1);
    check("tmo_busy", bus.busy, 1'b0);
    tick(1);
    check("tmo_single", bus.frame_err, 1'b0);
    tick(10);
    check("tmo_count", errs - e0, 1);
    check("tmo_no_tx", tx_q.size(), 0);
    do_frame(8'h02, 8'hF0, 8'h3C, 0, "resync_and");

    // Byte arriving on the terminal-count cycle is accepted
    tx_q.delete();
    e0 = errs;
    send_byte(8'h01);
    tick(49);
    send_byte(8'h10);
    tick(49);
    send_byte(8'h20);
    wait_idle("tc_accept");
    check_resp("tc_accept", 16'hF006);
    check("tc_noerr", errs - e0, 0);

    // Overrun during HOLD_RES
    busy_len = 20;
    tx_q.delete();
    e0 = errs;
    send_byte(8'h03);
    send_byte(8'h0F);
    send_byte(8'hF0);
    wait_tx(1);
    tick(2);
    send_byte(8'hAA);
    check("ovr_pulse", bus.frame_err, 1'b1);
    check("ovr_busy", bus.busy, 1'b1);
    wait_idle("overrun");
    check_resp("overrun", ref_resp(8'h03, 8'h0F, 8'hF0));
    check("ovr_count", errs - e0, 1);

    // Reset during HOLD_RES abandons the status byte
    tx_q.delete();
    send_byte(8'h00);
    send_byte(8'h20);
    send_byte(8'h30);
    wait_tx(1);
    tick(3);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_start", bus.tx_start, 1'b0);
    check("mid_rst_tx_data", bus.tx_data, 8'h00);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_frame_err", bus.frame_err, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(40);
    check("mid_rst_no_status", tx_q.size(), 1);
    do_frame(8'h04, 8'hAA, 8'h0F, 0, "post_rst_xor");

    // Randomized frames against the reference model
    for (int i = 0; i < 25; i++) begin
      busy_len = $urandom_range(0, 6);
      op = 8'($urandom_range(0, 9));
      if (op > 8'd7) op = 8'($urandom_range(8, 255));
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      do_frame(op, a, b, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end
    check("final_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
